// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: instruction type/op encodings, FSM states and flag layout.
// The multiply path is only built when ALU_MUL_EN is defined.
package alu_pkg;

    typedef enum logic [1:0] {
        A_TYPE = 2'b00,
        M_TYPE = 2'b01,
        R_TYPE = 2'b10,
        B_TYPE = 2'b11
    } instr_type_e;

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000,
        OP_PASS = 5'b00001,
        OP_OR   = 5'b00010,
        OP_AND  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_XOR  = 5'b00101,
        OP_SHL  = 5'b00110,
        OP_SHR  = 5'b00111,
        OP_MUL  = 5'b01000
    } alu_op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; product holds the low DATA_W bits.
// Instantiated by alu_seq_unit only when ALU_MUL_EN is defined.
module alu_mul_iter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;

    // product is the accumulator after this cycle's step, so it is valid in the same cycle as done
    always_comb begin
        acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
        product  = acc_next;
        done     = busy_reg && (cnt_reg == CNT_W'(DATA_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with registered result and flags; ready/valid on both sides with back-pressure.
// Define ALU_MUL_EN to build the iterative multiplier and the MUL_BUSY state.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] rn,
    input  logic [DATA_W-1:0] rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] rd,
    output logic [3:0]        flags,
    output logic              illegal
);
    instr_type_e        itype;
    alu_op_e            op;
    logic [SHAMT_W-1:0] sh;
    logic [DATA_W:0]    add_full;
    logic [DATA_W:0]    sub_full;
    logic [DATA_W:0]    shl_full;
    logic [DATA_W-1:0]  res;
    logic               res_carry;
    logic               res_ovf;
    logic               res_illegal;
    logic               is_mul;
    alu_flags_t         res_flags;
    logic               accept;
    logic               unused_bits;

    assign itype       = instr_type_e'(instr[15:14]);
    assign op          = alu_op_e'(instr[13:9]);
    assign sh          = rm[SHAMT_W-1:0];
    assign unused_bits = ^instr[8:0];
    assign accept      = in_valid && in_ready;

    always_comb begin
        add_full    = {1'b0, rn} + {1'b0, rm};
        sub_full    = {1'b0, rn} + {1'b0, ~rm} + (DATA_W+1)'(1);
        // the extra top bit catches the last bit shifted out; it stays 0 for sh == 0
        shl_full    = {1'b0, rn} << sh;
        res         = '0;
        res_carry   = 1'b0;
        res_ovf     = 1'b0;
        res_illegal = 1'b0;
        is_mul      = 1'b0;
        if (itype == A_TYPE) begin
            case (op)
                OP_ADD: begin
                    res       = add_full[DATA_W-1:0];
                    res_carry = add_full[DATA_W];
                    res_ovf   = (rn[DATA_W-1] == rm[DATA_W-1]) && (res[DATA_W-1] != rn[DATA_W-1]);
                end
                OP_PASS: res = rn;
                OP_OR:   res = rn | rm;
                OP_AND:  res = rn & rm;
                OP_SUB: begin
                    res       = sub_full[DATA_W-1:0];
                    res_carry = sub_full[DATA_W];
                    res_ovf   = (rn[DATA_W-1] != rm[DATA_W-1]) && (res[DATA_W-1] != rn[DATA_W-1]);
                end
                OP_XOR:  res = rn ^ rm;
                OP_SHL: begin
                    res       = shl_full[DATA_W-1:0];
                    res_carry = shl_full[DATA_W];
                end
                OP_SHR:  res = rn >> sh;
`ifdef ALU_MUL_EN
                OP_MUL:  is_mul = 1'b1;
`endif
                default: res_illegal = 1'b1;
            endcase
        end
        res_flags = '0;
        if (itype == A_TYPE && !res_illegal) begin
            res_flags = '{zero: (res == '0), neg: res[DATA_W-1], carry: res_carry, ovf: res_ovf};
        end
    end

`ifdef ALU_MUL_EN
    alu_state_e        state;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (rn),
        .b       (rm),
        .done    (mul_done),
        .product (mul_product)
    );

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rd        <= '0;
            flags     <= '0;
            illegal   <= 1'b0;
`ifdef ALU_MUL_EN
            state     <= IDLE;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ALU_MUL_EN
            if (accept && is_mul) begin
                state <= MUL_BUSY;
            end else if (accept) begin
                rd        <= res;
                flags     <= res_flags;
                illegal   <= res_illegal;
                out_valid <= 1'b1;
            end else if (state == MUL_BUSY && mul_done) begin
                rd        <= mul_product;
                flags     <= {(mul_product == '0), mul_product[DATA_W-1], 2'b00};
                illegal   <= 1'b0;
                out_valid <= 1'b1;
                state     <= IDLE;
            end
`else
            if (accept) begin
                rd        <= res;
                flags     <= res_flags;
                illegal   <= res_illegal;
                out_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed and randomized checks of alu_seq_unit against an arithmetic reference model.
// Expectations for MUL follow ALU_MUL_EN.
module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instr = '0;
    logic [15:0] rn = '0;
    logic [15:0] rm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] rd;
    logic [3:0]  flags;
    logic        illegal;

    int vectors = 0;
    int miscompares = 0;
    logic busy_ready_seen;

    alu_seq_unit #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rn        (rn),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic over the op table; flags packed {zero,neg,carry,ovf}
    task automatic model(input logic [1:0] t, input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [3:0] f, output logic il, output int lat);
        int ua, ub, sa, sb, full, s;
        bit c, v;
        ua = int'(a); ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        c = 0; v = 0; r = '0; f = '0; il = 0; lat = 1; full = 0;
        if (t != 2'b00) return;
        case (o)
            5'd0: begin full = ua + ub; r = full[15:0]; c = full[16]; s = sa + sb; v = (s > 32767) || (s < -32768); end
            5'd1: r = a;
            5'd2: r = a | b;
            5'd3: r = a & b;
            5'd4: begin full = ua + (65535 - ub) + 1; r = full[15:0]; c = full[16]; s = sa - sb; v = (s > 32767) || (s < -32768); end
            5'd5: r = a ^ b;
            5'd6: begin full = ua << b[3:0]; r = full[15:0]; c = full[16]; end
            5'd7: r = a >> b[3:0];
`ifdef ALU_MUL_EN
            5'd8: begin full = ua * ub; r = full[15:0]; lat = 17; end
`endif
            default: il = 1;
        endcase
        if (!il) f = {(r == 16'h0), r[15], c, v};
    endtask

    task automatic do_op(input logic [1:0] t, input logic [4:0] o, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r_o, output logic [3:0] f_o, output logic il_o, output int lat_o);
        int w = 0;
        instr = {t, o, 9'h000}; rn = a; rm = b; in_valid = 1'b1;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        check("accept_wait", (w < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_ready_seen = 1'b0;
        lat_o = 1;
        while (!out_valid && lat_o < 100) begin
            if (in_ready) busy_ready_seen = 1'b1;
            @(posedge clk); #1; lat_o++;
        end
        vectors++;
        r_o = rd; f_o = flags; il_o = illegal;
        $display("op t=%0d o=%0d rn=%h rm=%h -> rd=%h flags=%b illegal=%0d lat=%0d", t, o, a, b, rd, flags, illegal, lat_o);
    endtask

    initial begin
        logic [15:0] r_o, e_r;
        logic [3:0]  f_o, e_f;
        logic        il_o, e_il;
        int          lat_o, e_lat, any_valid;
        logic [1:0]  t;
        logic [4:0]  o;
        logic [15:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_rd", rd, 0);
        check("rst_flags", flags, 0);
        check("rst_illegal", illegal, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(2'b00, 5'b00000, 16'hFFFF, 16'h0001, r_o, f_o, il_o, lat_o);
        check("add_rd", r_o, 16'h0000);
        check("add_flags", f_o, 4'b1010);
        check("add_lat", lat_o, 1);

        do_op(2'b00, 5'b00100, 16'h8000, 16'h0001, r_o, f_o, il_o, lat_o);
        check("sub_rd", r_o, 16'h7FFF);
        check("sub_flags", f_o, 4'b0011);

        do_op(2'b00, 5'b00001, 16'h1234, 16'hABCD, r_o, f_o, il_o, lat_o);
        check("pass_rd", r_o, 16'h1234);

        do_op(2'b00, 5'b00010, 16'h00F0, 16'h0F00, r_o, f_o, il_o, lat_o);
        out_ready = 1'b0;
        check("or_rd", r_o, 16'h0FF0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_rd", rd, 16'h0FF0);
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;

        do_op(2'b00, 5'b01000, 16'h0003, 16'h0005, r_o, f_o, il_o, lat_o);
`ifdef ALU_MUL_EN
        check("mul_rd", r_o, 16'h000F);
        check("mul_illegal", il_o, 0);
        check("mul_lat", lat_o, 17);
        check("mul_busy_in_ready", busy_ready_seen, 0);
`else
        check("mul_rd", r_o, 16'h0000);
        check("mul_illegal", il_o, 1);
        check("mul_lat", lat_o, 1);
`endif

        do_op(2'b00, 5'b11111, 16'h5555, 16'h3333, r_o, f_o, il_o, lat_o);
        check("undef_rd", r_o, 16'h0000);
        check("undef_illegal", il_o, 1);
        do_op(2'b01, 5'b00000, 16'h5555, 16'h3333, r_o, f_o, il_o, lat_o);
        check("mtype_rd", r_o, 16'h0000);
        check("mtype_flags", f_o, 4'b0000);
        check("mtype_illegal", il_o, 0);

        do_op(2'b00, 5'b00110, 16'h8001, 16'h0000, r_o, f_o, il_o, lat_o);
        check("shl0_rd", r_o, 16'h8001);
        check("shl0_flags", f_o, 4'b0100);
        do_op(2'b00, 5'b00110, 16'h4001, 16'h0002, r_o, f_o, il_o, lat_o);
        check("shl2_rd", r_o, 16'h0004);
        check("shl2_flags", f_o, 4'b0010);

        for (int n = 0; n < 60; n++) begin
            int sel;
            sel = $urandom_range(0, 11);
            t = 2'b00;
            o = 5'(sel);
            if (sel == 9) o = 5'($urandom_range(9, 31));
            if (sel == 10) begin t = 2'($urandom_range(1, 3)); o = 5'($urandom_range(0, 31)); end
            if (sel == 11) o = 5'd8;
            a = 16'($urandom);
            b = 16'($urandom);
            if (n % 7 == 0) b = '0;
            model(t, o, a, b, e_r, e_f, e_il, e_lat);
            do_op(t, o, a, b, r_o, f_o, il_o, lat_o);
            check("rand_rd", r_o, e_r);
            check("rand_illegal", il_o, e_il);
            check("rand_lat", lat_o, e_lat);
            if (!e_il) check("rand_flags", f_o, e_f);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                @(posedge clk); #1;
                check("rand_hold_rd", rd, e_r);
                check("rand_hold_valid", out_valid, 1);
                out_ready = 1'b1;
            end
        end

        // Reset while a multiply is in flight: nothing may come out afterwards
        instr = {2'b00, 5'b01000, 9'h000}; rn = 16'h0007; rm = 16'h0009; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        any_valid = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) any_valid = 1;
        end
        check("midrst_no_output", any_valid, 0);
        do_op(2'b00, 5'b00000, 16'h0002, 16'h0002, r_o, f_o, il_o, lat_o);
        check("post_rst_add", r_o, 16'h0004);
        check("post_rst_flags", f_o, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
